// File: rtl/alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: aluOp codes, slice signal codes, FSM states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SIG_AND  = 2'b00,
    SIG_OR   = 2'b01,
    SIG_ADD  = 2'b10,
    SIG_LESS = 2'b11
  } slice_sig_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FILL,
    ST_DONE
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  function automatic logic op_inverts_b(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic slice_sig_e op_signal(input alu_op_e op);
    case (op)
      OP_AND:  return SIG_AND;
      OP_OR:   return SIG_OR;
      default: return SIG_ADD;
    endcase
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// WIDTH-bit right-shift register with parallel load and serial input at the MSB.
module serial_shreg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {sin, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bitserial_alu_seq.sv
// Multi-cycle sequencer driving an external 1-bit ALU slice LSB-first.
// Optional SERIAL_ALU_OVF_EN adds an overflow output and a signed-correct SLT.
module bitserial_alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef SERIAL_ALU_OVF_EN
  output logic             overflow,
`endif
  output logic             sliceA,
  output logic             sliceB,
  output logic             sliceCin,
  output logic [1:0]       sliceSignal,
  output logic             sliceInvertB,
  output logic             sliceLess,
  input  logic             sliceOut,
  input  logic             sliceCout
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             set_q, set_d;
  logic             zero_q, zero_d;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             accept, shift_ops, shift_res, last_bit;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_next;

  serial_shreg #(.WIDTH(WIDTH)) u_opa (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(opA),
    .shift(shift_ops), .sin(1'b0), .q(opa_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_opb (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(opB),
    .shift(shift_ops), .sin(1'b0), .q(opb_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val('0),
    .shift(shift_res), .sin(sliceOut), .q(res_q)
  );

  // Only the LSB of each operand register feeds the slice; upper bits just shift through.
  logic unused_op_hi;
  assign unused_op_hi = ^{opa_q[WIDTH-1:1], opb_q[WIDTH-1:1]};

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_next = {sliceOut, res_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    set_d        = set_q;
    zero_d       = zero_q;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d        = ovf_q;
`endif
    accept       = 1'b0;
    shift_ops    = 1'b0;
    shift_res    = 1'b0;
    sliceA       = 1'b0;
    sliceB       = 1'b0;
    sliceCin     = 1'b0;
    sliceSignal  = SIG_AND;
    sliceInvertB = 1'b0;
    sliceLess    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          cnt_d  = '0;
          zero_d = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
          ovf_d  = 1'b0;
`endif
          if (op_valid(aluOp)) begin
            op_d    = alu_op_e'(aluOp);
            carry_d = op_inverts_b(alu_op_e'(aluOp));
            state_d = ST_CALC;
          end else begin
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_CALC: begin
        sliceA       = opa_q[0];
        sliceB       = opb_q[0];
        sliceCin     = carry_q;
        sliceSignal  = op_signal(op_q);
        sliceInvertB = op_inverts_b(op_q);
        shift_ops    = 1'b1;
        shift_res    = 1'b1;
        carry_d      = sliceCout;
        cnt_d        = cnt_q + CW'(1);
        if (last_bit) begin
          cnt_d = '0;
          // carry_q is the carry into the MSB; xor with its carry out gives signed overflow
`ifdef SERIAL_ALU_OVF_EN
          ovf_d = (op_q != OP_AND) && (op_q != OP_OR) && (carry_q ^ sliceCout);
          set_d = sliceOut ^ carry_q ^ sliceCout;
`else
          set_d = sliceOut;
`endif
          if (op_q == OP_SLT) begin
            state_d = ST_FILL;
          end else begin
            zero_d  = (res_next == '0);
            state_d = ST_DONE;
          end
        end
      end

      ST_FILL: begin
        sliceSignal  = SIG_LESS;
        sliceInvertB = 1'b1;
        sliceLess    = (cnt_q == '0) ? set_q : 1'b0;
        shift_res    = 1'b1;
        cnt_d        = cnt_q + CW'(1);
        if (last_bit) begin
          cnt_d   = '0;
          zero_d  = (res_next == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      set_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      set_q   <= set_d;
      zero_q  <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FILL);
  assign done   = (state_q == ST_DONE);
  assign result = res_q;
  assign zero   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Randomized bench for bitserial_alu_seq (WIDTH=8) with a behavioural 1-bit slice and an arithmetic reference model.
module tb_bitserial_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   aluOp;
  logic [W-1:0] opA, opB;
  logic         busy, done, zero;
  logic [W-1:0] result;
`ifdef SERIAL_ALU_OVF_EN
  logic         overflow;
`endif
  logic         sliceA, sliceB, sliceCin, sliceInvertB, sliceLess;
  logic [1:0]   sliceSignal;
  logic         sliceOut, sliceCout;

  bitserial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluOp(aluOp), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result), .zero(zero),
`ifdef SERIAL_ALU_OVF_EN
    .overflow(overflow),
`endif
    .sliceA(sliceA), .sliceB(sliceB), .sliceCin(sliceCin), .sliceSignal(sliceSignal),
    .sliceInvertB(sliceInvertB), .sliceLess(sliceLess),
    .sliceOut(sliceOut), .sliceCout(sliceCout)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice
  logic slice_bb;
  always_comb begin
    slice_bb  = sliceB ^ sliceInvertB;
    sliceCout = (sliceA & slice_bb) | (sliceA & sliceCin) | (slice_bb & sliceCin);
    case (sliceSignal)
      2'b00:   sliceOut = sliceA & slice_bb;
      2'b01:   sliceOut = sliceA | slice_bb;
      2'b10:   sliceOut = sliceA ^ slice_bb ^ sliceCin;
      default: sliceOut = sliceLess;
    endcase
  end

  logic [6:0] slice_vec;
  assign slice_vec = {sliceA, sliceB, sliceCin, sliceSignal, sliceInvertB, sliceLess};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operands
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic o, output int lat);
    int sa, sb, s;
    logic [W-1:0] diff;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    diff = a - b;
    o    = 1'b0;
    lat  = W + 1;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin s = sa + sb; r = a + b; o = (s > 127) || (s < -128); end
      3'd3: begin s = sa - sb; r = diff;  o = (s > 127) || (s < -128); end
      3'd4: begin
        s = sa - sb;
        o = (s > 127) || (s < -128);
`ifdef SERIAL_ALU_OVF_EN
        r = {{(W-1){1'b0}}, (sa < sb)};
`else
        r = {{(W-1){1'b0}}, diff[W-1]};
`endif
        lat = 2 * W + 1;
      end
      default: begin r = '0; lat = 1; end
    endcase
    z = (r == '0);
  endfunction

  // Transaction under test; written by the driver only while no transaction is in flight
  logic [2:0]   cur_op;
  logic [W-1:0] cur_a, cur_b, exp_r;
  logic         exp_z, exp_o;
  int           exp_lat;
  int           acc_cyc;
  int           req_id = 0;
  int           done_id = 0;
  logic         hold = 1'b1;

  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;
  logic         last_o = 1'b0;

  int           t, k, lowm, cin_k;
  logic         inv;
  logic [1:0]   exp_sig;
  logic [W-1:0] bb;

  // Per-cycle compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      last_r = '0;
      last_z = 1'b0;
      last_o = 1'b0;
    end else if (!hold) begin
      if (req_id != done_id) begin
        t = cyc - acc_cyc + 1;
        if (t < exp_lat) begin
          check("busy_during_op", busy, 1);
          check("done_early", done, 0);
          inv     = (cur_op == 3'd3) || (cur_op == 3'd4);
          exp_sig = (cur_op == 3'd0) ? 2'b00 : (cur_op == 3'd1) ? 2'b01 : 2'b10;
          if (t <= W) begin
            k     = t - 1;
            bb    = inv ? ~cur_b : cur_b;
            lowm  = (1 << k) - 1;
            cin_k = (((int'(cur_a) & lowm) + (int'(bb) & lowm) + int'(inv)) >> k) & 1;
            check("slice_calc", slice_vec,
                  {cur_a[k], cur_b[k], cin_k[0], exp_sig, inv, 1'b0});
          end else begin
            k = t - W - 1;
            check("slice_fill", slice_vec,
                  {3'b000, 2'b11, 1'b1, (k == 0) ? exp_r[0] : 1'b0});
          end
        end else begin
          check("done", done, 1);
          check("busy_at_done", busy, 0);
          check("slice_at_done", slice_vec, 0);
          check("result", result, exp_r);
          check("zero", zero, exp_z);
`ifdef SERIAL_ALU_OVF_EN
          check("overflow", overflow, exp_o);
          last_o = exp_o;
`endif
          last_r  = exp_r;
          last_z  = exp_z;
          done_id = done_id + 1;
        end
      end else begin
        check("idle_ctl_slice", {busy, done, slice_vec}, 0);
        check("idle_result_held", {zero, result}, {last_z, last_r});
`ifdef SERIAL_ALU_OVF_EN
        check("idle_overflow_held", overflow, last_o);
`endif
      end
    end
  end

  task automatic finish_bench();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // poke > 0: raise a stray start in cycle 'poke' after accept (busy or DONE); poke < 0: random choice
  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    int p;
    @(negedge clk);
    cur_op = op;
    cur_a  = a;
    cur_b  = b;
    model(op, a, b, exp_r, exp_z, exp_o, exp_lat);
    aluOp = op;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_id  = req_id + 1;
    start   = 1'b0;
    aluOp   = 3'($urandom);
    opA     = W'($urandom);
    opB     = W'($urandom);
    p = poke;
    if (p < 0) p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, exp_lat)) : 0;
    if (p > 0) begin
      repeat (p - 1) @(posedge clk);
      #1;
      start = 1'b1;
      aluOp = 3'($urandom_range(0, 4));
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 100 && req_id != done_id; i++) @(posedge clk);
    if (req_id != done_id) begin
      check("done_timeout", 1, 0);
      finish_bench();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] m_r;
  logic         m_z, m_o;
  int           m_lat;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    aluOp = '0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl_slice", {busy, done, zero, slice_vec}, 0);
    check("reset_result", result, 0);
`ifdef SERIAL_ALU_OVF_EN
    check("reset_overflow", overflow, 0);
`endif
    #2 rst_n = 1'b1;
    hold = 1'b0;

    // Pin the reference model with hand-computed values
    model(3'd2, 8'h7F, 8'h01, m_r, m_z, m_o, m_lat);
    check("model_add", {m_r, m_z, m_o, 8'(m_lat)}, {8'h80, 1'b0, 1'b1, 8'd9});
    model(3'd3, 8'h05, 8'h05, m_r, m_z, m_o, m_lat);
    check("model_sub", {m_r, m_z, m_o}, {8'h00, 1'b1, 1'b0});
    model(3'd4, 8'hFE, 8'h03, m_r, m_z, m_o, m_lat);
    check("model_slt_lt", {m_r, 8'(m_lat)}, {8'h01, 8'd17});
    model(3'd4, 8'h03, 8'hFE, m_r, m_z, m_o, m_lat);
    check("model_slt_ge", {m_r, m_z}, {8'h00, 1'b1});
    model(3'd0, 8'hF0, 8'h3C, m_r, m_z, m_o, m_lat);
    check("model_and", m_r, 8'h30);
    model(3'd1, 8'hF0, 8'h3C, m_r, m_z, m_o, m_lat);
    check("model_or", m_r, 8'hFC);
    model(3'd7, 8'h12, 8'h34, m_r, m_z, m_o, m_lat);
    check("model_invalid", {m_r, m_z, 8'(m_lat)}, {8'h00, 1'b1, 8'd1});

    // Directed cases
    run(3'd2, 8'h7F, 8'h01, 0);
    run(3'd3, 8'h05, 8'h05, 0);
    run(3'd4, 8'hFE, 8'h03, 0);
    run(3'd4, 8'h03, 8'hFE, 0);
    run(3'd0, 8'hF0, 8'h3C, 0);
    run(3'd1, 8'hF0, 8'h3C, 0);
    run(3'd7, 8'h12, 8'h34, 1);
    run(3'd2, 8'h11, 8'h22, W + 1);
    run(3'd4, 8'h80, 8'h01, 5);
    run(3'd3, 8'h00, 8'h01, 3);
    run(3'd2, 8'hFF, 8'h01, 0);

    // Asynchronous reset in CALC bit 4
    hold = 1'b1;
    @(negedge clk);
    aluOp = 3'd2;
    opA   = 8'h5A;
    opB   = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctl_slice", {busy, done, slice_vec}, 0);
    check("midreset_result", {zero, result}, 0);
`ifdef SERIAL_ALU_OVF_EN
    check("midreset_overflow", overflow, 0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    hold = 1'b0;
    run(3'd2, 8'h5A, 8'h33, 0);

    // Randomized traffic, including invalid ops and stray starts
    for (int n = 0; n < 60; n++) begin
      run(3'($urandom_range(0, 7)), pick(), pick(), -1);
    end

    repeat (3) @(posedge clk);
    finish_bench();
  end

endmodule
